// File: rtl/split_acc_pkg.sv
// Shared defaults, FSM state type and width helpers for the split sample accumulator.
package split_acc_pkg;

    localparam int DEFAULT_DATA_W    = 16;
    localparam int DEFAULT_NUM_LANES = 5;
    localparam int DEFAULT_ACC_W     = 64;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lane_acc.sv
// One accumulator lane: running sum and sum of squares.
// SPLIT_ACC_SAT_EN selects saturating adds plus a sticky saturation flag; default wraps.
module lane_acc
    import split_acc_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ACC_W  = DEFAULT_ACC_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  add_en,
    input  logic [DATA_W-1:0]     sample,
    input  logic [2*DATA_W-1:0]   square,
    output logic [ACC_W-1:0]      sum,
    output logic [ACC_W-1:0]      sum_square
`ifdef SPLIT_ACC_SAT_EN
    ,
    output logic                  saturated
`endif
);

    logic [ACC_W-1:0] sum_nxt;
    logic [ACC_W-1:0] sq_nxt;

`ifdef SPLIT_ACC_SAT_EN
    // One spare bit above the widest operand catches every carry out of ACC_W.
    localparam int EXT_W = max_int(ACC_W, 2*DATA_W) + 1;

    logic [EXT_W-1:0] sum_ext;
    logic [EXT_W-1:0] sq_ext;
    logic             sum_sat;
    logic             sq_sat;

    always_comb begin
        sum_ext = EXT_W'(sum) + EXT_W'(sample);
        sq_ext  = EXT_W'(sum_square) + EXT_W'(square);
        sum_sat = |sum_ext[EXT_W-1:ACC_W];
        sq_sat  = |sq_ext[EXT_W-1:ACC_W];
        sum_nxt = sum_sat ? '1 : sum_ext[ACC_W-1:0];
        sq_nxt  = sq_sat  ? '1 : sq_ext[ACC_W-1:0];
    end
`else
    always_comb begin
        sum_nxt = sum + ACC_W'(sample);
        sq_nxt  = sum_square + ACC_W'(square);
    end
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum        <= '0;
            sum_square <= '0;
`ifdef SPLIT_ACC_SAT_EN
            saturated  <= 1'b0;
`endif
        end else if (clear) begin
            sum        <= '0;
            sum_square <= '0;
`ifdef SPLIT_ACC_SAT_EN
            saturated  <= 1'b0;
`endif
        end else if (add_en) begin
            sum        <= sum_nxt;
            sum_square <= sq_nxt;
`ifdef SPLIT_ACC_SAT_EN
            saturated  <= saturated | sum_sat | sq_sat;
`endif
        end
    end

endmodule

// File: rtl/sample_split_acc.sv
// Round-robin capture of a counted sample run into per-lane sum / sum-of-squares accumulators.
// Optional SPLIT_ACC_SAT_EN: saturating lanes and a sticky overflow output.
module sample_split_acc
    import split_acc_pkg::*;
#(
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int NUM_LANES = DEFAULT_NUM_LANES,
    parameter int ACC_W     = DEFAULT_ACC_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [31:0]       count,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [ACC_W-1:0]  sum_0,
    output logic [ACC_W-1:0]  sum_1,
    output logic [ACC_W-1:0]  sum_2,
    output logic [ACC_W-1:0]  sum_3,
    output logic [ACC_W-1:0]  sum_4,
    output logic [ACC_W-1:0]  sum_square_0,
    output logic [ACC_W-1:0]  sum_square_1,
    output logic [ACC_W-1:0]  sum_square_2,
    output logic [ACC_W-1:0]  sum_square_3,
    output logic [ACC_W-1:0]  sum_square_4,
    output logic              busy,
    output logic              done
`ifdef SPLIT_ACC_SAT_EN
    ,
    output logic              overflow
`endif
);

    localparam int LANE_W    = clog2_min1(NUM_LANES);
    localparam int NUM_PORTS = 5;

    state_t              state;
    state_t              state_nxt;
    logic [31:0]         count_q;
    logic [31:0]         accepted;
    logic [LANE_W-1:0]   lane_ptr;
    logic                drain_cnt;
    logic                xfer;
    logic                last_xfer;
    logic                start_acc;

    logic                s1_valid;
    logic [DATA_W-1:0]   s1_data;
    logic [2*DATA_W-1:0] s1_square;
    logic [LANE_W-1:0]   s1_lane;

    logic [ACC_W-1:0]    sum_vec [NUM_PORTS];
    logic [ACC_W-1:0]    sq_vec  [NUM_PORTS];
`ifdef SPLIT_ACC_SAT_EN
    logic [NUM_PORTS-1:0] sat_vec;
`endif

    assign start_acc = (state == ST_IDLE) && start;
    assign in_ready  = (state == ST_RUN) && (accepted < count_q);
    assign xfer      = in_valid && in_ready;
    assign last_xfer = xfer && (accepted == count_q - 32'd1);

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE:  if (start) state_nxt = (count == 32'd0) ? ST_DONE : ST_RUN;
            ST_RUN: begin
                busy = 1'b1;
                if (last_xfer) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (drain_cnt) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            count_q   <= '0;
            accepted  <= '0;
            lane_ptr  <= '0;
            drain_cnt <= 1'b0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= (state == ST_DRAIN) && !drain_cnt;
            if (start_acc) begin
                count_q  <= count;
                accepted <= '0;
                lane_ptr <= '0;
            end else if (xfer) begin
                accepted <= accepted + 32'd1;
                lane_ptr <= (lane_ptr == LANE_W'(NUM_LANES - 1)) ? '0 : lane_ptr + 1'b1;
            end
        end
    end

    // Stage 1: register the sample, its full-width square and its destination lane.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_data   <= '0;
            s1_square <= '0;
            s1_lane   <= '0;
        end else begin
            s1_valid  <= xfer;
            s1_data   <= in_data;
            s1_square <= (2*DATA_W)'(in_data) * (2*DATA_W)'(in_data);
            s1_lane   <= lane_ptr;
        end
    end

    // Stage 2: the addressed lane accumulates; unused output slots read as zero.
    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_lane
        if (g < NUM_LANES) begin : g_acc
            lane_acc #(
                .DATA_W (DATA_W),
                .ACC_W  (ACC_W)
            ) u_lane (
                .clk        (clk),
                .reset      (reset),
                .clear      (start_acc),
                .add_en     (s1_valid && (s1_lane == LANE_W'(g))),
                .sample     (s1_data),
                .square     (s1_square),
                .sum        (sum_vec[g]),
                .sum_square (sq_vec[g])
`ifdef SPLIT_ACC_SAT_EN
                ,
                .saturated  (sat_vec[g])
`endif
            );
        end else begin : g_tie
            assign sum_vec[g] = '0;
            assign sq_vec[g]  = '0;
`ifdef SPLIT_ACC_SAT_EN
            assign sat_vec[g] = 1'b0;
`endif
        end
    end

`ifdef SPLIT_ACC_SAT_EN
    assign overflow = |sat_vec;
`endif

    assign sum_0        = sum_vec[0];
    assign sum_1        = sum_vec[1];
    assign sum_2        = sum_vec[2];
    assign sum_3        = sum_vec[3];
    assign sum_4        = sum_vec[4];
    assign sum_square_0 = sq_vec[0];
    assign sum_square_1 = sq_vec[1];
    assign sum_square_2 = sq_vec[2];
    assign sum_square_3 = sq_vec[3];
    assign sum_square_4 = sq_vec[4];

endmodule

// File: tb/tb_sample_split_acc.sv
// Scoreboard bench for sample_split_acc: default 64-bit instance plus a 20-bit instance
// sharing all inputs to exercise accumulator wrap (or saturation with SPLIT_ACC_SAT_EN).
module tb_sample_split_acc;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] count;
    logic        in_valid;
    logic [15:0] in_data;

    logic        in_ready, busy, done;
    logic [63:0] s0, s1, s2, s3, s4, q0, q1, q2, q3, q4;
    logic        in_ready20, busy20, done20;
    logic [19:0] t0, t1, t2, t3, t4, r0, r1, r2, r3, r4;
`ifdef SPLIT_ACC_SAT_EN
    logic        overflow, overflow20;
`endif

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [4:0][63:0] s;
        logic [4:0][63:0] q;
    } exp_t;

    exp_t exp_q [$];

    always #5 clk = ~clk;

    sample_split_acc dut (
        .clk(clk), .reset(reset), .start(start), .count(count),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .sum_0(s0), .sum_1(s1), .sum_2(s2), .sum_3(s3), .sum_4(s4),
        .sum_square_0(q0), .sum_square_1(q1), .sum_square_2(q2),
        .sum_square_3(q3), .sum_square_4(q4),
        .busy(busy), .done(done)
`ifdef SPLIT_ACC_SAT_EN
        , .overflow(overflow)
`endif
    );

    sample_split_acc #(.ACC_W(20)) dut20 (
        .clk(clk), .reset(reset), .start(start), .count(count),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready20),
        .sum_0(t0), .sum_1(t1), .sum_2(t2), .sum_3(t3), .sum_4(t4),
        .sum_square_0(r0), .sum_square_1(r1), .sum_square_2(r2),
        .sum_square_3(r3), .sum_square_4(r4),
        .busy(busy20), .done(done20)
`ifdef SPLIT_ACC_SAT_EN
        , .overflow(overflow20)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected 20-bit lane value derived from the exact (64-bit) total.
    function automatic logic [19:0] to20(input logic [63:0] v);
`ifdef SPLIT_ACC_SAT_EN
        return (v > 64'hFFFFF) ? 20'hFFFFF : v[19:0];
`else
        return v[19:0];
`endif
    endfunction

    // Monitor: every done pulse retires one scoreboard entry.
    always @(negedge clk) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", {63'd0, done}, 64'd0);
            end else begin
                exp_t e;
                logic [4:0][63:0] as, aq;
                logic [4:0][19:0] bs, bq;
                logic             ovf;
                e  = exp_q.pop_front();
                as = {s4, s3, s2, s1, s0};
                aq = {q4, q3, q2, q1, q0};
                bs = {t4, t3, t2, t1, t0};
                bq = {r4, r3, r2, r1, r0};
                ovf = 1'b0;
                check("done20", {63'd0, done20}, 64'd1);
                for (int i = 0; i < 5; i++) begin
                    check($sformatf("sum_%0d", i), as[i], e.s[i]);
                    check($sformatf("sum_square_%0d", i), aq[i], e.q[i]);
                    check($sformatf("w20 sum_%0d", i), {44'd0, bs[i]}, {44'd0, to20(e.s[i])});
                    check($sformatf("w20 sum_square_%0d", i), {44'd0, bq[i]}, {44'd0, to20(e.q[i])});
                    if (e.s[i] > 64'hFFFFF || e.q[i] > 64'hFFFFF) ovf = 1'b1;
                end
`ifdef SPLIT_ACC_SAT_EN
                check("overflow", {63'd0, overflow}, 64'd0);
                check("w20 overflow", {63'd0, overflow20}, {63'd0, ovf});
`endif
            end
        end
    end

    task automatic push_exp(input logic [4:0][63:0] s, input logic [4:0][63:0] q);
        exp_t e;
        e.s = s;
        e.q = q;
        exp_q.push_back(e);
    endtask

    // Entered at a negedge in IDLE; returns at the negedge after the start edge.
    task automatic start_run(input logic [31:0] c);
        start = 1'b1;
        count = c;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Presents one sample; returns at the negedge following its transfer edge.
    task automatic send(input logic [15:0] v);
        int guard = 0;
        in_valid = 1'b1;
        in_data  = v;
        while (!in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) check("in_ready_timeout", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Counts negedges from the one after the last transfer until done is seen.
    task automatic wait_done(input string name);
        int lat = 0;
        while (!done && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check(name, lat, 64'd2);
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        count    = '0;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (2) @(negedge clk);
        check("reset in_ready", {63'd0, in_ready}, 64'd0);
        check("reset busy", {63'd0, busy}, 64'd0);
        check("reset done", {63'd0, done}, 64'd0);
        check("reset sum_0", s0, 64'd0);
        check("reset sum_square_4", q4, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Five back-to-back samples, one per lane.
        push_exp({64'd5, 64'd4, 64'd3, 64'd2, 64'd1}, {64'd25, 64'd16, 64'd9, 64'd4, 64'd1});
        start_run(5);
        check("busy in run", {63'd0, busy}, 64'd1);
        for (int i = 1; i <= 5; i++) send(16'(i));
        wait_done("done latency 5x");

        // Seven samples wrap the lane pointer; an extra offered sample is refused.
        push_exp({64'd10, 64'd10, 64'd10, 64'd20, 64'd20}, {64'd100, 64'd100, 64'd100, 64'd200, 64'd200});
        start_run(7);
        for (int i = 0; i < 7; i++) send(16'd10);
        check("in_ready after 7th", {63'd0, in_ready}, 64'd0);
        in_valid = 1'b1;
        in_data  = 16'd99;
        wait_done("done latency 7x");
        in_valid = 1'b0;

        // Empty run: straight to DONE with accumulators cleared.
        push_exp('0, '0);
        start_run(0);
        check("count0 done", {63'd0, done}, 64'd1);
        check("count0 in_ready", {63'd0, in_ready}, 64'd0);
        @(negedge clk);

        // Full-scale samples with a bubble after each one.
        push_exp({5{64'h1FFFE}}, {5{64'h1_FFFC_0002}});
        start_run(10);
        for (int i = 0; i < 10; i++) begin
            send(16'hFFFF);
            if (i < 9) @(negedge clk);
        end
        wait_done("done latency gaps");

        // Reset mid-run discards the run without a done pulse.
        start_run(5);
        for (int i = 1; i <= 3; i++) send(16'(i));
        reset = 1'b1;
        #1;
        check("mid reset sum_0", s0, 64'd0);
        check("mid reset busy", {63'd0, busy}, 64'd0);
        check("mid reset in_ready", {63'd0, in_ready}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        push_exp({64'd5, 64'd4, 64'd3, 64'd2, 64'd1}, {64'd25, 64'd16, 64'd9, 64'd4, 64'd1});
        start_run(5);
        for (int i = 1; i <= 5; i++) send(16'(i));
        wait_done("done latency after reset");

        // Twenty full-scale samples: squares exceed 20 bits in the narrow instance.
        push_exp({5{64'h3FFFC}}, {5{64'h3_FFF8_0004}});
        start_run(20);
        for (int i = 0; i < 20; i++) send(16'hFFFF);
        wait_done("done latency 20x");

        repeat (3) @(negedge clk);
        check("scoreboard empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
